deinterleaver_prime_stream: RTL and testbench
=============================================

DEINTERLEAVER_PRIME_STREAM -- requirements
Module: deinterleaver_prime_stream

Interface
REQ-001 The block SHALL have parameter N, default 10, meaning block length in samples.
REQ-002 The block SHALL have parameter P, default 3, meaning prime step, with 0 < P < N and gcd(P,N)=1.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning sample width (shortreal bit pattern).
REQ-004 Port clk, input, 1, meaning the single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1, meaning synchronous, active-high reset.
REQ-006 Port in_data, input, DATA_WIDTH, meaning interleaved sample.
REQ-007 Port in_valid, input, 1, meaning in_data is valid.
REQ-008 Port in_ready, output, 1, meaning the block can accept a sample.
REQ-009 Port out_data, output, DATA_WIDTH, meaning deinterleaved sample.
REQ-010 Port out_valid, output, 1, meaning out_data is valid.
REQ-011 Port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-012 Port out_last, output, 1, meaning out_data is sample N-1 of the block.

Function
REQ-013 Mapping SHALL invert the prime forward interleaver out[j]=in[(j*P) mod N]: input sample j of a block SHALL be written to address (j*P) mod N and read out in ascending address order.
REQ-014 Write address SHALL be generated incrementally: start 0, add P per accepted sample, subtract N when the sum is >= N; no multiplier or divider.
REQ-015 Storage SHALL be two N-entry banks (ping-pong), so one block fills while the other drains.
REQ-016 A transfer SHALL occur on either side only when valid and ready are both high at a rising edge.
REQ-017 Write FSM states: W_FILL (in_ready=1, accepting into current bank) and W_WAIT (in_ready=0, target bank not yet drained).
REQ-018 W_FILL: on accepting sample N-1, mark bank full, toggle write bank; go to W_WAIT if the new bank is still full, else stay W_FILL.
REQ-019 W_WAIT: go to W_FILL in the cycle after the target bank's last sample is accepted downstream.
REQ-020 Read FSM states: R_IDLE (out_valid=0) and R_DRAIN (out_valid=1, presenting read-bank address count).
REQ-021 Latency: if read side is R_IDLE when sample N-1 is accepted at edge k, out_valid SHALL be high with address-0 data after edge k+1.
REQ-022 R_DRAIN: each downstream transfer advances address; after the address-(N-1) transfer, free bank, toggle read bank, and go R_DRAIN with address 0 presented next cycle if the other bank is full, else R_IDLE.
REQ-023 With out_valid=1 and out_ready=0, out_data, out_valid and out_last SHALL hold stable.
REQ-024 out_last SHALL be 1 exactly while address N-1 is presented.
REQ-025 Simultaneous completion of a write block and a read block in one cycle SHALL be legal; no sample lost or duplicated, sustained throughput one sample/cycle.
REQ-026 in_valid while in_ready=0 SHALL be ignored, sample not consumed.

Reset
REQ-027 On reset: in_ready=1 (W_FILL), out_valid=0, out_last=0, out_data=0, R_IDLE, both banks empty, write/read bank select 0, all addresses and counters 0.
REQ-028 Reset mid-block SHALL discard any partial or undrained block; bank contents need not be cleared.

Structure
REQ-029 A shared package interleaver_pkg SHALL hold default N, P, DATA_WIDTH, a data typedef, and FSM state enums.
REQ-030 An elaboration-time check SHALL fail if gcd(P,N)!=1 or P>=N.
REQ-031 The incremental address generator SHALL be sub-module prime_addr_gen (start, step, wrap, count, done).

Verification
REQ-032 Reset, feed {1,4,7,10,3,6,9,2,5,8} as shortreal bits, out_ready=1 -> output 1..10 in order, out_last on 10.
REQ-033 Three back-to-back blocks, in_valid and out_ready held 1 -> in_ready never drops after first block, outputs continuous, 30 correct samples.
REQ-034 out_ready=0 with two full banks -> in_ready=0 after 20 inputs, 21st sample held; release -> all samples correct in order.
REQ-035 Random in_valid/out_ready gaps, 100 blocks -> output equals forward interleaver inverse per block, out_last every 10th transfer.
REQ-036 Reset after 6 inputs -> outputs idle; next full block 1..10 deinterleaves correctly with no stale data.
REQ-037 Parameters N=7, P=5 -> input forward-interleaved 1..7 returns 1..7.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared definitions for the prime-step interleaver family: default geometry,
// the sample type, the write/read FSM state types and a gcd helper used to
// reject parameter sets for which the prime-step mapping is not a permutation.
package interleaver_pkg;

    localparam int DEFAULT_N          = 10;
    localparam int DEFAULT_P          = 3;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] Sample;

    typedef enum logic {
        W_FILL,
        W_WAIT
    } WriteState;

    typedef enum logic {
        R_IDLE,
        R_DRAIN
    } ReadState;

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

endpackage

// File: rtl/prime_addr_gen.sv
// Incremental prime-step address generator. Produces START, START+STEP, ...
// modulo WRAP using only an adder and a compare-subtract, and flags the last
// address of a WRAP-long block so the caller knows a block is complete.
module prime_addr_gen
    import interleaver_pkg::*;
#(
    parameter int START = 0,
    parameter int STEP  = DEFAULT_P,
    parameter int WRAP  = DEFAULT_N,
    parameter int AW    = (WRAP > 1) ? $clog2(WRAP) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          done
);

    localparam logic [AW:0]   WRAP_V    = (AW + 1)'(WRAP);
    localparam logic [AW-1:0] LAST_CNT  = AW'(WRAP - 1);
    localparam logic [AW-1:0] START_V   = AW'(START);

    logic [AW-1:0] count;
    logic [AW:0]   sum;
    logic          wrap;

    // Candidate next address and whether it has stepped past the block length
    always_comb begin
        sum  = {1'b0, addr} + (AW + 1)'(STEP);
        wrap = (sum >= WRAP_V);
    end

    assign done = (count == LAST_CNT);

    // Advance address and sample count; restart cleanly at the end of a block
    always_ff @(posedge clk) begin
        if (reset) begin
            addr  <= START_V;
            count <= '0;
        end else if (advance) begin
            if (done) begin
                addr  <= START_V;
                count <= '0;
            end else begin
                count <= count + AW'(1);
                addr  <= wrap ? AW'(sum - WRAP_V) : sum[AW-1:0];
            end
        end
    end

endmodule

// File: rtl/deinterleaver_prime_stream.sv
// Streaming deinterleaver for a prime-step block interleaver. Incoming sample j
// of a block lands at address (j*P) mod N of one of two ping-pong banks; a full
// bank is then drained in ascending address order while the other one fills.
module deinterleaver_prime_stream
    import interleaver_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int P          = DEFAULT_P,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int            AW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    if (P <= 0 || P >= N || gcd(P, N) != 1) begin : gBadParams
        $error("deinterleaver_prime_stream: P must satisfy 0 < P < N and gcd(P,N) == 1");
    end

    logic [DATA_WIDTH-1:0] mem [2][N];

    WriteState     wrState;
    ReadState      rdState;
    logic [1:0]    bankFull;
    logic          wrBank;
    logic          rdBank;
    logic [AW-1:0] wrAddr;
    logic [AW-1:0] rdAddr;
    logic [AW-1:0] rdNext;
    logic          wrDone;
    logic          inXfer;
    logic          outXfer;
    logic          wrLast;
    logic          rdLast;
    logic          otherReadable;
    logic          nextWritable;

    assign in_ready = (wrState == W_FILL);

    // Handshake decode plus look-ahead on same-cycle completions so a block can
    // finish on both sides at once without inserting a bubble
    always_comb begin
        inXfer        = in_valid && in_ready;
        outXfer       = out_valid && out_ready;
        wrLast        = inXfer && wrDone;
        rdLast        = outXfer && (rdAddr == LAST_ADDR);
        rdNext        = rdAddr + AW'(1);
        otherReadable = bankFull[~rdBank] || (wrLast && (wrBank != rdBank));
        nextWritable  = !bankFull[~wrBank] || (rdLast && (rdBank != wrBank));
    end

    prime_addr_gen #(
        .START (0),
        .STEP  (P),
        .WRAP  (N),
        .AW    (AW)
    ) uWriteAddr (
        .clk     (clk),
        .reset   (reset),
        .advance (inXfer),
        .addr    (wrAddr),
        .done    (wrDone)
    );

    // Sample storage; contents are deliberately left untouched by reset
    always_ff @(posedge clk) begin
        if (inXfer) begin
            mem[wrBank][wrAddr] <= in_data;
        end
    end

    // Bank occupancy: set when the last sample is written, cleared when drained
    always_ff @(posedge clk) begin
        if (reset) begin
            bankFull <= 2'b00;
        end else begin
            if (wrLast) begin
                bankFull[wrBank] <= 1'b1;
            end
            if (rdLast) begin
                bankFull[rdBank] <= 1'b0;
            end
        end
    end

    // Write FSM: fill the current bank, then wait while the next one is occupied
    always_ff @(posedge clk) begin
        if (reset) begin
            wrState <= W_FILL;
            wrBank  <= 1'b0;
        end else begin
            case (wrState)
                W_FILL: begin
                    if (wrLast) begin
                        wrBank <= ~wrBank;
                        if (!nextWritable) begin
                            wrState <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (!bankFull[wrBank] || (rdLast && (rdBank == wrBank))) begin
                        wrState <= W_FILL;
                    end
                end
                default: wrState <= W_FILL;
            endcase
        end
    end

    // Read FSM: present one registered sample per address and hold it until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            rdState   <= R_IDLE;
            rdBank    <= 1'b0;
            rdAddr    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (rdState)
                R_IDLE: begin
                    if (bankFull[rdBank]) begin
                        rdState   <= R_DRAIN;
                        rdAddr    <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_data  <= mem[rdBank][AW'(0)];
                    end
                end
                R_DRAIN: begin
                    if (outXfer) begin
                        if (rdAddr == LAST_ADDR) begin
                            rdBank   <= ~rdBank;
                            rdAddr   <= '0;
                            out_last <= 1'b0;
                            if (otherReadable) begin
                                out_data <= mem[~rdBank][AW'(0)];
                            end else begin
                                rdState   <= R_IDLE;
                                out_valid <= 1'b0;
                            end
                        end else begin
                            rdAddr   <= rdNext;
                            out_data <= mem[rdBank][rdNext];
                            out_last <= (rdNext == LAST_ADDR);
                        end
                    end
                end
                default: rdState <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deinterleaver_prime_stream.sv
// Self-checking bench for deinterleaver_prime_stream: directed known-answer
// blocks, back-to-back streaming, back-pressure, random gaps, mid-block reset
// and an N=7/P=5 instance, all scored against a block-level inverse model.
module tb_deinterleaver_prime_stream;
    import interleaver_pkg::*;

    localparam int N = 10;
    localparam int P = 3;

    logic  clk = 1'b0;
    logic  reset;
    Sample in_data;
    logic  in_valid;
    logic  in_ready;
    Sample out_data;
    logic  out_valid;
    logic  out_ready;
    logic  out_last;

    Sample in_data7;
    logic  in_valid7;
    logic  in_ready7;
    Sample out_data7;
    logic  out_valid7;
    logic  out_ready7;
    logic  out_last7;

    int vectors     = 0;
    int miscompares = 0;

    Sample inQ[$];
    Sample expQ[$];
    Sample blk[N];
    Sample ob[N];
    int    blkCount = 0;
    int    outCount = 0;
    bit    useModel = 1'b0;
    bit    prevStall = 1'b0;
    Sample prevData;
    logic  prevLast;

    int cycleNo      = 0;
    int accCount     = 0;
    int xferCount    = 0;
    int firstXferCyc = 0;
    int lastXferCyc  = 0;
    int readyLowLate = 0;

    Sample got7[$];
    logic  gotLast7[$];

    always #5 clk = ~clk;

    deinterleaver_prime_stream #(.N(N), .P(P), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    deinterleaver_prime_stream #(.N(7), .P(5), .DATA_WIDTH(32)) dut7 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data7),
        .in_valid  (in_valid7),
        .in_ready  (in_ready7),
        .out_data  (out_data7),
        .out_valid (out_valid7),
        .out_ready (out_ready7),
        .out_last  (out_last7)
    );

    // IEEE-754 single-precision bit pattern of a small positive integer
    function automatic Sample floatBits(input int v);
        int e;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((v << (23 - e)) & 32'h007F_FFFF)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer queued samples with random valid gaps and random downstream ready
    task automatic applyStimulus(input int validPct, input int readyPct, input int maxCycles);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < inQ.size() && cyc < maxCycles) begin
            in_valid  = ($urandom_range(99) < validPct);
            in_data   = inQ[idx];
            out_ready = ($urandom_range(99) < readyPct);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("feedAccepted", idx, inQ.size());
        inQ.delete();
    endtask

    task automatic drainOutputs(input int readyPct, input int maxCycles);
        int cyc;
        cyc = 0;
        while (expQ.size() > 0 && cyc < maxCycles) begin
            out_ready = ($urandom_range(99) < readyPct);
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b1;
        checkOutput("drainRemaining", expQ.size(), 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid7 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard: rebuild each accepted block with the inverse prime mapping and
    // score every downstream transfer, including hold-while-stalled behaviour
    always @(negedge clk) begin
        if (reset) begin
            blkCount  = 0;
            outCount  = 0;
            prevStall = 1'b0;
            expQ.delete();
        end else begin
            cycleNo++;
            if (!in_ready && accCount >= 21 && accCount < 30) readyLowLate++;
            if (in_valid && in_ready) begin
                blk[blkCount] = in_data;
                blkCount++;
                accCount++;
                if (blkCount == N) begin
                    if (useModel) begin
                        for (int j = 0; j < N; j++) ob[(j * P) % N] = blk[j];
                        for (int a = 0; a < N; a++) expQ.push_back(ob[a]);
                    end
                    blkCount = 0;
                end
            end
            if (prevStall) begin
                checkOutput("holdValid", out_valid, 1'b1);
                checkOutput("holdData", out_data, prevData);
                checkOutput("holdLast", out_last, prevLast);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("[TB] FAIL spuriousOut observed=%h expected=none", out_data);
                end else begin
                    checkOutput("outData", out_data, expQ.pop_front());
                    checkOutput("outLast", out_last, (outCount % N) == (N - 1));
                end
                outCount++;
                if (xferCount == 0) firstXferCyc = cycleNo;
                lastXferCyc = cycleNo;
                xferCount++;
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
        end
    end

    // Capture the N=7 instance's output stream
    always @(negedge clk) begin
        if (!reset && out_valid7 && out_ready7) begin
            got7.push_back(out_data7);
            gotLast7.push_back(out_last7);
        end
    end

    initial begin
        int seqA[10] = '{1, 4, 7, 10, 3, 6, 9, 2, 5, 8};
        Sample s21;
        int idx;
        int cyc;

        reset      = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_data7   = '0;
        in_valid7  = 1'b0;
        out_ready7 = 1'b1;

        doReset();
        checkOutput("resetInReady", in_ready, 1'b1);
        checkOutput("resetOutValid", out_valid, 1'b0);
        checkOutput("resetOutLast", out_last, 1'b0);
        checkOutput("resetOutData", out_data, 32'h0);

        $display("[TB] known-answer block");
        useModel = 1'b0;
        for (int k = 1; k <= N; k++) expQ.push_back(floatBits(k));
        for (int i = 0; i < N; i++) inQ.push_back(floatBits(seqA[i]));
        applyStimulus(100, 100, 200);
        checkOutput("latencyBefore", out_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("latencyValid", out_valid, 1'b1);
        checkOutput("latencyData", out_data, floatBits(1));
        drainOutputs(100, 200);

        $display("[TB] three back-to-back blocks");
        useModel  = 1'b1;
        accCount  = 0;
        xferCount = 0;
        readyLowLate = 0;
        for (int i = 0; i < 3 * N; i++) inQ.push_back($urandom);
        applyStimulus(100, 100, 200);
        drainOutputs(100, 200);
        checkOutput("b2bAccepted", accCount, 3 * N);
        checkOutput("b2bTransfers", xferCount, 3 * N);
        checkOutput("b2bContinuous", lastXferCyc - firstXferCyc + 1, 3 * N);
        checkOutput("b2bReadyThirdBlock", readyLowLate, 0);

        $display("[TB] back-pressure with both banks full");
        accCount = 0;
        for (int i = 0; i < 2 * N; i++) inQ.push_back($urandom);
        applyStimulus(100, 0, 200);
        s21       = $urandom;
        in_valid  = 1'b1;
        in_data   = s21;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stallInReady", in_ready, 1'b0);
            checkOutput("stallOutValid", out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("stallAccepted", accCount, 2 * N);
        inQ.push_back(s21);
        for (int i = 1; i < N; i++) inQ.push_back($urandom);
        applyStimulus(100, 100, 200);
        drainOutputs(100, 200);

        $display("[TB] 100 blocks with random gaps");
        for (int i = 0; i < 100 * N; i++) inQ.push_back($urandom);
        applyStimulus(70, 70, 20000);
        drainOutputs(70, 2000);

        $display("[TB] reset in mid-block");
        for (int i = 0; i < 6; i++) inQ.push_back($urandom);
        applyStimulus(100, 100, 50);
        doReset();
        out_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checkOutput("postResetIdle", out_valid, 1'b0);
            checkOutput("postResetReady", in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        useModel = 1'b0;
        for (int k = 1; k <= N; k++) expQ.push_back(floatBits(k));
        for (int i = 0; i < N; i++) inQ.push_back(floatBits(seqA[i]));
        applyStimulus(100, 100, 200);
        drainOutputs(100, 200);

        $display("[TB] N=7 P=5 instance");
        idx = 0;
        cyc = 0;
        out_ready7 = 1'b1;
        while (idx < 7 && cyc < 50) begin
            in_valid7 = 1'b1;
            in_data7  = floatBits(((idx * 5) % 7) + 1);
            @(negedge clk);
            if (in_ready7) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid7 = 1'b0;
        cyc = 0;
        while (got7.size() < 7 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("n7Count", got7.size(), 7);
        for (int k = 0; k < got7.size(); k++) begin
            checkOutput("n7Data", got7[k], floatBits(k + 1));
            checkOutput("n7Last", gotLast7[k], k == 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
